// File: rtl/mips_pkg.sv
// Opcode and funct encodings shared by the MIPS execute-stage ALU.
package mips_pkg;

  localparam int unsigned DataW = 32;

  // Opcode field [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Funct field, meaningful only under OP_RTYPE
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

endpackage

// File: rtl/mips_alu_core.sv
// Purely combinational ALU datapath: result mux, compares, shifter, branch condition.
module mips_alu_core
  import mips_pkg::*;
(
  input  logic [5:0]       opcode,
  input  logic [DataW-1:0] rs_val,
  input  logic [DataW-1:0] rt_val,
  input  logic [4:0]       shamt,
  input  logic [5:0]       func,
  input  logic [15:0]      raw_val,
  output logic [DataW-1:0] result,
  output logic             branch
);

  logic [DataW-1:0] simm;
  logic [DataW-1:0] zimm;
  logic [DataW-1:0] diff;
  logic [4:0]       sh;
  logic             slt_rt;
  logic             sltu_rt;
  logic             slt_imm;
  logic             sltu_imm;

  assign simm     = {{16{raw_val[15]}}, raw_val};
  assign zimm     = {16'h0000, raw_val};
  assign diff     = rs_val - rt_val;
  assign slt_rt   = $signed(rs_val) < $signed(rt_val);
  assign sltu_rt  = rs_val < rt_val;
  assign slt_imm  = $signed(rs_val) < $signed(simm);
  assign sltu_imm = rs_val < simm;
  // Variable shifts take their amount from rs, fixed shifts from the shamt field.
  assign sh       = func[2] ? rs_val[4:0] : shamt;

  always_comb begin
    result = '0;
    branch = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADD, FN_ADDU: result = rs_val + rt_val;
          FN_SUB, FN_SUBU: result = diff;
          FN_AND:          result = rs_val & rt_val;
          FN_OR:           result = rs_val | rt_val;
          FN_XOR:          result = rs_val ^ rt_val;
          FN_NOR:          result = ~(rs_val | rt_val);
          FN_SLT:          result = {31'b0, slt_rt};
          FN_SLTU:         result = {31'b0, sltu_rt};
          FN_SLL, FN_SLLV: result = rt_val << sh;
          FN_SRL, FN_SRLV: result = rt_val >> sh;
          FN_SRA, FN_SRAV: result = $unsigned($signed(rt_val) >>> sh);
          default:         result = '0;
        endcase
      end
      OP_ADDI, OP_ADDIU,
      OP_LW, OP_SW: result = rs_val + simm;
      OP_SLTI:      result = {31'b0, slt_imm};
      OP_SLTIU:     result = {31'b0, sltu_imm};
      OP_ANDI:      result = rs_val & zimm;
      OP_ORI:       result = rs_val | zimm;
      OP_XORI:      result = rs_val ^ zimm;
      OP_LUI:       result = {raw_val, 16'h0000};
      OP_BEQ: begin
        result = diff;
        branch = rs_val == rt_val;
      end
      OP_BNE: begin
        result = diff;
        branch = rs_val != rt_val;
      end
      OP_BLEZ: begin
        result = diff;
        branch = rs_val[31] || (rs_val == '0);
      end
      OP_BGTZ: begin
        result = diff;
        branch = !rs_val[31] && (rs_val != '0);
      end
      default: begin
        result = '0;
        branch = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_alu.sv
// Registered MIPS execute-stage ALU: combinational core plus one output register stage.
module mips_alu
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        OPCODE,
  input  logic [DataW-1:0]  RS_VAL,
  input  logic [DataW-1:0]  RT_VAL,
  input  logic [4:0]        SHAMT,
  input  logic [5:0]        FUNC,
  input  logic [15:0]       RAW_VAL,
  output logic [DataW-1:0]  RESULT,
  output logic              SIG_B
);

  logic [DataW-1:0] result_d;
  logic [DataW-1:0] result_q;
  logic             sig_b_d;
  logic             sig_b_q;

  mips_alu_core u_core (
    .opcode  (OPCODE),
    .rs_val  (RS_VAL),
    .rt_val  (RT_VAL),
    .shamt   (SHAMT),
    .func    (FUNC),
    .raw_val (RAW_VAL),
    .result  (result_d),
    .branch  (sig_b_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      sig_b_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      sig_b_q  <= sig_b_d;
    end
  end

  assign RESULT = result_q;
  assign SIG_B  = sig_b_q;

endmodule

// File: tb/tb_mips_alu.sv
// Directed-vector bench for mips_alu: reset, table of operations, reset/timing sequences.
module tb_mips_alu;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [5:0]  OPCODE;
  logic [31:0] RS_VAL;
  logic [31:0] RT_VAL;
  logic [4:0]  SHAMT;
  logic [5:0]  FUNC;
  logic [15:0] RAW_VAL;
  logic [31:0] RESULT;
  logic        SIG_B;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sa;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] raw;
    logic [31:0] exp_r;
    logic        exp_b;
  } vec_t;

  localparam int NumVec = 32;
  vec_t vecs [NumVec];

  mips_alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .OPCODE  (OPCODE),
    .RS_VAL  (RS_VAL),
    .RT_VAL  (RT_VAL),
    .SHAMT   (SHAMT),
    .FUNC    (FUNC),
    .RAW_VAL (RAW_VAL),
    .RESULT  (RESULT),
    .SIG_B   (SIG_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_r(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: RESULT got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: SIG_B got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sa,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] raw);
    OPCODE  = op;
    FUNC    = fn;
    SHAMT   = sa;
    RS_VAL  = rs;
    RT_VAL  = rt;
    RAW_VAL = raw;
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sa,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic [15:0] raw, input logic [31:0] er, input logic eb);
    vec_t v;
    v.op = op; v.fn = fn; v.sa = sa; v.rs = rs; v.rt = rt; v.raw = raw;
    v.exp_r = er; v.exp_b = eb;
    return v;
  endfunction

  initial begin
    //             op        fn       sa  rs            rt            raw       result        b
    vecs[0]  = mk(OP_SW,    6'h00,   0, 32'd15,       32'd12,       16'd19,   32'd34,       0);
    vecs[1]  = mk(OP_SW,    6'h00,   0, 32'd23,       32'd2,        16'd14,   32'd37,       0);
    vecs[2]  = mk(OP_SW,    6'h00,   0, 32'd1,        32'd35,       16'd8,    32'd9,        0);
    vecs[3]  = mk(OP_LW,    6'h00,   0, 32'h100,      32'h0,        16'hFFF0, 32'h000000F0, 0);
    vecs[4]  = mk(OP_RTYPE, FN_SUB,  0, 32'd5,        32'd7,        16'h0,    32'hFFFFFFFE, 0);
    vecs[5]  = mk(OP_RTYPE, FN_SLT,  0, 32'd5,        32'd7,        16'h0,    32'd1,        0);
    vecs[6]  = mk(OP_RTYPE, FN_SLTU, 0, 32'hFFFFFFFF, 32'd1,        16'h0,    32'd0,        0);
    vecs[7]  = mk(OP_RTYPE, FN_SRA,  4, 32'h0,        32'h80000000, 16'h0,    32'hF8000000, 0);
    vecs[8]  = mk(OP_ANDI,  6'h00,   0, 32'hFFFFFFFF, 32'h0,        16'h8001, 32'h00008001, 0);
    vecs[9]  = mk(OP_LUI,   6'h00,   0, 32'hDEADBEEF, 32'h0,        16'h1234, 32'h12340000, 0);
    vecs[10] = mk(OP_BEQ,   6'h00,   0, 32'd9,        32'd9,        16'h0,    32'h0,        1);
    vecs[11] = mk(OP_BNE,   6'h00,   0, 32'd9,        32'd9,        16'h0,    32'h0,        0);
    vecs[12] = mk(OP_BGTZ,  6'h00,   0, 32'd0,        32'd3,        16'h0,    32'hFFFFFFFD, 0);
    vecs[13] = mk(6'h3F,    6'h00,   0, 32'd5,        32'd7,        16'h1234, 32'h0,        0);
    vecs[14] = mk(OP_RTYPE, FN_SLT,  0, 32'hFFFFFFFF, 32'd1,        16'h0,    32'd1,        0);
    vecs[15] = mk(OP_RTYPE, FN_ADD,  0, 32'hFFFFFFFF, 32'd2,        16'h0,    32'd1,        0);
    vecs[16] = mk(OP_RTYPE, FN_NOR,  0, 32'h0,        32'h0,        16'h0,    32'hFFFFFFFF, 0);
    vecs[17] = mk(OP_RTYPE, FN_SRL, 31, 32'h0,        32'h80000000, 16'h0,    32'd1,        0);
    vecs[18] = mk(OP_RTYPE, FN_SLLV, 0, 32'h24,       32'd1,        16'h0,    32'h10,       0);
    vecs[19] = mk(OP_RTYPE, FN_SRAV, 0, 32'd1,        32'h80000000, 16'h0,    32'hC0000000, 0);
    vecs[20] = mk(OP_RTYPE, FN_SLL,  0, 32'h0,        32'h0,        16'h0,    32'h0,        0);
    vecs[21] = mk(OP_RTYPE, FN_SLL,  0, 32'h55,       32'h1234,     16'h0,    32'h1234,     0);
    vecs[22] = mk(OP_SLTI,  6'h00,   0, 32'hFFFFFFFE, 32'h0,        16'hFFFF, 32'd1,        0);
    vecs[23] = mk(OP_SLTIU, 6'h00,   0, 32'd5,        32'h0,        16'hFFFF, 32'd1,        0);
    vecs[24] = mk(OP_XORI,  6'h00,   0, 32'hFFFF0000, 32'h0,        16'h00FF, 32'hFFFF00FF, 0);
    vecs[25] = mk(OP_BLEZ,  6'h00,   0, 32'h80000000, 32'h0,        16'h0,    32'h80000000, 1);
    vecs[26] = mk(OP_BGTZ,  6'h00,   0, 32'd1,        32'd0,        16'h0,    32'd1,        1);
    vecs[27] = mk(OP_RTYPE, 6'h3F,   0, 32'd5,        32'd7,        16'h0,    32'h0,        0);
    vecs[28] = mk(OP_ADDI,  6'h00,   0, 32'd10,       32'h0,        16'hFFFF, 32'd9,        0);
    vecs[29] = mk(OP_ORI,   6'h00,   0, 32'hF0F00000, 32'h0,        16'h0F0F, 32'hF0F00F0F, 0);
    vecs[30] = mk(OP_RTYPE, FN_XOR,  0, 32'hFF00FF00, 32'h0FF00FF0, 16'h0,    32'hF0F0F0F0, 0);
    vecs[31] = mk(OP_RTYPE, FN_AND,  0, 32'hFF00FF00, 32'h0FF00FF0, 16'h0,    32'h0F000F00, 0);

    // Reset with random inputs: outputs zero immediately and while held.
    rst_n = 1'b0;
    drive(6'($urandom), 6'($urandom), 5'($urandom), $urandom, $urandom, 16'($urandom));
    #1;
    check_r("reset_now", RESULT, 32'h0);
    check_b("reset_now", SIG_B, 1'b0);
    repeat (3) begin
      @(negedge clk);
      drive(OP_SW, 6'h00, 5'd0, 32'd1, 32'd1, 16'd1);
    end
    @(posedge clk); #1;
    check_r("reset_held", RESULT, 32'h0);
    check_b("reset_held", SIG_B, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_r("reset_release", RESULT, 32'h0);

    // Back-to-back vectors, one per cycle, each checked one cycle later.
    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].fn, vecs[i].sa, vecs[i].rs, vecs[i].rt, vecs[i].raw);
      @(posedge clk); #1;
      check_r($sformatf("vec%0d_op%02h_fn%02h", i, vecs[i].op, vecs[i].fn), RESULT, vecs[i].exp_r);
      check_b($sformatf("vec%0d_op%02h_fn%02h", i, vecs[i].op, vecs[i].fn), SIG_B, vecs[i].exp_b);
    end

    // Mid-stream reset discards the held result; zero persists until the next edge.
    @(negedge clk);
    drive(OP_RTYPE, FN_ADDU, 5'd0, 32'd1, 32'd1, 16'h0);
    @(posedge clk); #1;
    check_r("pre_reset", RESULT, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_r("async_reset", RESULT, 32'h0);
    @(negedge clk);
    drive(OP_BEQ, 6'h00, 5'd0, 32'd3, 32'd3, 16'h0);
    @(posedge clk); #1;
    check_r("reset_edge", RESULT, 32'h0);
    check_b("reset_edge", SIG_B, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_b("after_release", SIG_B, 1'b0);
    @(posedge clk); #1;
    check_r("first_after_reset", RESULT, 32'h0);
    check_b("first_after_reset", SIG_B, 1'b1);

    // Input change between edges must not reach the registered outputs.
    drive(OP_RTYPE, FN_SUB, 5'd0, 32'd100, 32'd1, 16'h0);
    #2;
    check_r("mid_cycle_hold", RESULT, 32'h0);
    check_b("mid_cycle_hold", SIG_B, 1'b1);
    @(posedge clk); #1;
    check_r("mid_cycle_capture", RESULT, 32'd99);
    check_b("mid_cycle_capture", SIG_B, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_alu.md
# mips_alu

Registered MIPS-style integer ALU for the execute stage of the single-issue datapath. It takes decoded instruction fields (opcode, funct, shamt, 16-bit immediate) and the two register operands. It produces a 32-bit result (arithmetic/logic value or load/store effective address) and a branch-taken flag. Outputs are registered, so results appear one clock after the operands.

## Interface
Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- none (widths fixed: data 32, opcode/funct 6, shamt 5, immediate 16)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- OPCODE  input  6  instruction opcode field [31:26]
- RS_VAL  input  32  rs operand value
- RT_VAL  input  32  rt operand value
- SHAMT  input  5  shift amount field
- FUNC  input  6  funct field (used only when OPCODE = 000000)
- RAW_VAL  input  16  raw immediate field [15:0]
- RESULT  output  32  registered ALU result
- SIG_B  output  1  registered branch-taken flag

## Operation
- simm = sign-extend(RAW_VAL); zimm = zero-extend(RAW_VAL).
- All add/sub are modulo 2^32. No overflow traps and no overflow output: add and addu behave identically.
- R-type (OPCODE 000000), selected by FUNC:
  - 100000/100001: add/addu, RS+RT
  - 100010/100011: sub/subu, RS−RT
  - 100100 AND; 100101 OR; 100110 XOR; 100111 NOR
  - 101010 slt: signed RS<RT → 1 else 0
  - 101011 sltu: unsigned compare, same encoding
  - 000000 sll, 000010 srl, 000011 sra: RT shifted by SHAMT
  - 000100 sllv, 000110 srlv, 000111 srav: RT shifted by RS[4:0]
- I-type, selected by OPCODE:
  - 001000/001001 addi/addiu: RS+simm
  - 001010 slti: signed compare RS<simm
  - 001011 sltiu: unsigned compare RS<simm (simm sign-extended, then compared unsigned)
  - 001100 andi, 001101 ori, 001110 xori: use zimm
  - 001111 lui: {RAW_VAL,16'h0}
  - 100011 lw, 101011 sw: effective address RS+simm
- Branches:
  - 000100 beq: SIG_B = (RS==RT)
  - 000101 bne: SIG_B = (RS!=RT)
  - 000110 blez: SIG_B = signed RS≤0
  - 000111 bgtz: SIG_B = signed RS>0
  - RESULT = RS−RT for all branches.
- SIG_B is 0 for every non-branch opcode.
- Unknown OPCODE, or unknown FUNC under R-type: RESULT=0, SIG_B=0.
- sll with SHAMT=0 and RT=0 (the NOP encoding) yields RESULT=0.
- Shifts by 0 pass RT unchanged. sra/srav replicate RT[31].

## Timing
- Combinational compute; RESULT and SIG_B captured on rising clk.
- Latency 1 cycle. A new operation is accepted every cycle; no handshake.
- rst_n low: RESULT=0 and SIG_B=0 immediately, regardless of clk. Registers hold 0 until the first rising edge after rst_n deasserts.
- Reset asserted mid-stream discards the in-flight result. There is no recovery of that value.
- Inputs must be stable for setup/hold around the rising edge. Mid-cycle input changes do not affect the outputs.

## Structure
- Shared package `mips_pkg`: opcode localparams (OP_RTYPE, OP_ADDI, …, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_LUI) and funct localparams (FN_ADD … FN_SRAV).
- One natural sub-module: `mips_alu_core`, the purely combinational datapath (result mux, comparisons, shifter, branch condition). The top level adds only the output register and reset.

## Test plan
- Reset: rst_n=0 with random inputs → RESULT=0 and SIG_B=0 immediately and while held.
- sw address generation, one per cycle, each result one cycle later:
  - OPCODE=101011, RS=15, RT=12, RAW=19 → RESULT=34, SIG_B=0
  - RS=23, RT=2, RAW=14 → RESULT=37
  - RS=1, RT=35, RAW=8 → RESULT=9
- Negative immediate: lw, RS=0x100, RAW=16'hFFF0 → RESULT=0xF0.
- R-type:
  - sub, RS=5, RT=7 → 0xFFFFFFFE
  - slt → 1; sltu, RS=0xFFFFFFFF, RT=1 → 0
  - sra, RT=0x80000000, SHAMT=4 → 0xF8000000
- Immediates:
  - andi, RS=0xFFFFFFFF, RAW=16'h8001 → 0x00008001
  - lui, RAW=16'h1234 → 0x12340000
- Branches and illegal codes:
  - beq, RS=RT=9 → SIG_B=1, RESULT=0; bne on the same operands → SIG_B=0
  - bgtz, RS=0 → SIG_B=0
  - OPCODE=111111 → RESULT=0, SIG_B=0
